seq_ctrl: RTL and testbench
===========================

# seq_ctrl

Parametrised instruction sequencer that sits between the data latch and the instruction decoder. It owns the instruction register and the cycle counter, which the decoder previously took as external inputs. It also latches and prioritises reset, NMI and a vector of IRQ lines. When an interrupt is taken it injects the interrupt opcode in place of the fetched opcode, so the decoder can run its interrupt sequence.

## Interface

Parameters:

- INST_W, 8: opcode width.
- CYC_W, 3: cycle counter width. MAX_CYC = 2**CYC_W-1.
- IRQ_N, 4: number of maskable IRQ lines, 1..16.
- SRC_W, 2: width of irq_src, clog2(IRQ_N), minimum 1.
- INT_OP, 8'h00: opcode injected for reset/NMI/IRQ service.

Ports:

- clk  in  1  single clock; all state updates on the rising edge.
- clr  in  1  reset, synchronous, active-high.
- dbus  in  INST_W  opcode from the data latch, valid while sync=1.
- icyc  in  1  decoder: advance the cycle counter.
- rcyc  in  1  decoder: last cycle of the instruction; next cycle is fetch.
- sinst  in  1  decoder: interrupt sequence started; acknowledge the serviced source.
- nmi  in  1  non-maskable request, edge-sensitive (rising).
- irq  in  IRQ_N  maskable requests, level-sensitive.
- irq_dis  in  1  status-register I flag; 1 masks all irq lines.
- inst  out  INST_W  current instruction to the decoder.
- cycle  out  CYC_W  current cycle within the instruction.
- sync  out  1  current cycle is an opcode-fetch cycle.
- int_rst, int_nmi, int_irq  out  1 each  one-hot cause of the current INT_OP sequence; all 0 for normal instructions.
- irq_src  out  SRC_W  index of the IRQ line serviced; valid while int_irq=1.
- overrun  out  1  sticky: cycle counter wrapped without rcyc.

## Operation

- Reset (clr=1 at an edge) produces: inst=INT_OP, cycle=0, sync=0, int_rst=1, int_nmi=0, int_irq=0, irq_src=0, overrun=0, nmi_pend=0, nmi_prev=0. The first cycle after reset is cycle 0 of the reset sequence. clr during any operation aborts it with identical results.
- Cycle counter, applied at each edge in priority order:
  - rcyc=1: cycle<=0, sync<=1.
  - else icyc=1: cycle<=cycle+1, sync<=0. At MAX_CYC it wraps to 0 and sets overrun.
  - else: cycle and sync hold (stall).
- Instruction register:
  - inst holds the previous opcode throughout the fetch cycle (sync=1), so the decoder can finish the previous instruction's tail work in cycle 0.
  - At the edge that ends the fetch cycle (sync=1 and the counter advances), inst loads either dbus or INST_OP according to the interrupt decision.
- Interrupt decision, evaluated at that load edge:
  - If nmi_pend: inst<=INT_OP, int_nmi<=1.
  - Else if irq_any = |irq and irq_dis=0: inst<=INT_OP, int_irq<=1, irq_src<=lowest asserted index.
  - Else: inst<=dbus and all int_* <= 0.
  - The NMI-over-IRQ priority is fixed. The int_* outputs and irq_src hold until the next load edge.
- NMI latch:
  - nmi_prev<=nmi every cycle. A rising edge (nmi & ~nmi_prev) sets nmi_pend.
  - sinst=1 while int_nmi=1 clears nmi_pend. If a new rising edge occurs in the same cycle, the set wins.
- IRQ lines are not latched. A line that drops before the load edge is not serviced. sinst has no effect on IRQ state.
- sinst while int_rst=1 clears int_rst at the next load edge only; no other effect.
- An opcode fetched as dbus==INST_OP with no pending source is a software interrupt: all int_* = 0.

## Timing

- Outputs are registered. There is no combinational path from inputs to outputs.
- The fetch cycle is the cycle after rcyc. The new inst is visible one cycle after that, together with cycle=1.
- Interrupt latency: an NMI edge sampled at edge k is serviced at the first load edge ≥ k+1. An IRQ must be asserted, and unmasked by irq_dis, at the load edge itself.
- rcyc and icyc together: rcyc wins.
- sinst and a new NMI edge together: nmi_pend stays 1.

## Test plan

- Reset, then icyc=1 held for 3 cycles: inst=8'h00, int_rst=1; cycle goes 0→1→2→3; overrun=0.
- Plain fetch: rcyc pulse, then dbus=8'hA9 with icyc=1 → sync=1 for one cycle; inst stays old during it; next cycle inst=8'hA9, cycle=1, int_*=0.
- IRQ priority: irq=4'b1010, irq_dis=0, at a fetch with dbus=8'h69 → inst=8'h00, int_irq=1, irq_src=1. Repeating with irq_dis=1 → inst=8'h69.
- NMI vs IRQ: NMI rising edge plus irq=4'b0001 → int_nmi=1, int_irq=0. sinst clears nmi_pend, so the next fetch services the IRQ with irq_src=0.
- Wrap: icyc=1 held for 8 cycles from cycle=0 with no rcyc → cycle returns to 0; overrun=1 and stays 1 until clr.
- clr mid-instruction at cycle=4: next cycle shows cycle=0, inst=8'h00, int_rst=1, overrun=0, and any pending NMI is discarded.

Source files
------------

// File: rtl/seq_ctrl.sv
// Instruction sequencer: owns the instruction register and cycle counter, and
// arbitrates reset/NMI/IRQ causes by injecting INT_OP at the opcode-load edge.
module seq_ctrl #(
  parameter int          INST_W = 8,
  parameter int          CYC_W  = 3,
  parameter int          IRQ_N  = 4,
  parameter int          SRC_W  = 2,
  parameter logic [INST_W-1:0] INT_OP = 8'h00
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [INST_W-1:0] dbus,
  input  logic              icyc,
  input  logic              rcyc,
  input  logic              sinst,
  input  logic              nmi,
  input  logic [IRQ_N-1:0]  irq,
  input  logic              irq_dis,
  output logic [INST_W-1:0] inst,
  output logic [CYC_W-1:0]  cycle,
  output logic              sync,
  output logic              int_rst,
  output logic              int_nmi,
  output logic              int_irq,
  output logic [SRC_W-1:0]  irq_src,
  output logic              overrun
);

  localparam logic [CYC_W-1:0] MAX_CYC = '1;

  logic nmi_pend;
  logic nmi_prev;
  logic load;
  logic nmi_rise;
  logic irq_take;

  function automatic logic [SRC_W-1:0] lowest_irq(input logic [IRQ_N-1:0] v);
    logic [SRC_W-1:0] r;
    r = '0;
    for (int i = IRQ_N - 1; i >= 0; i--) begin
      if (v[i]) r = SRC_W'(i);
    end
    return r;
  endfunction

  // The opcode is loaded on the edge that leaves the fetch cycle; rcyc keeps
  // the sequencer in fetch, so it suppresses the load.
  assign load     = sync & ~rcyc & icyc;
  assign nmi_rise = nmi & ~nmi_prev;
  assign irq_take = (|irq) & ~irq_dis;

  always_ff @(posedge clk) begin
    if (clr) begin
      inst     <= INT_OP;
      cycle    <= '0;
      sync     <= 1'b0;
      int_rst  <= 1'b1;
      int_nmi  <= 1'b0;
      int_irq  <= 1'b0;
      irq_src  <= '0;
      overrun  <= 1'b0;
      nmi_pend <= 1'b0;
      nmi_prev <= 1'b0;
    end else begin
      if (rcyc) begin
        cycle <= '0;
        sync  <= 1'b1;
      end else if (icyc) begin
        cycle <= cycle + 1'b1;
        sync  <= 1'b0;
        if (cycle == MAX_CYC) overrun <= 1'b1;
      end

      if (load) begin
        int_rst <= 1'b0;
        if (nmi_pend) begin
          inst    <= INT_OP;
          int_nmi <= 1'b1;
          int_irq <= 1'b0;
        end else if (irq_take) begin
          inst    <= INT_OP;
          int_nmi <= 1'b0;
          int_irq <= 1'b1;
          irq_src <= lowest_irq(irq);
        end else begin
          inst    <= dbus;
          int_nmi <= 1'b0;
          int_irq <= 1'b0;
        end
      end

      // A fresh edge beats the acknowledge so a back-to-back NMI is not lost.
      nmi_prev <= nmi;
      if (nmi_rise)
        nmi_pend <= 1'b1;
      else if (sinst && int_nmi)
        nmi_pend <= 1'b0;
    end
  end

endmodule

// File: tb/tb_seq_ctrl.sv
// Bench for seq_ctrl: directed test-plan steps then random traffic, each cycle
// compared against a cause-level behavioural model.
module tb_seq_ctrl;

  localparam int INST_W = 8;
  localparam int CYC_W  = 3;
  localparam int IRQ_N  = 4;
  localparam int SRC_W  = 2;
  localparam logic [7:0] INT_OP = 8'h00;
  localparam int NCYC = 1 << CYC_W;

  localparam int C_NONE = 0, C_RST = 1, C_NMI = 2, C_IRQ = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              clr, icyc, rcyc, sinst, nmi, irq_dis;
  logic [INST_W-1:0] dbus;
  logic [IRQ_N-1:0]  irq;
  logic [INST_W-1:0] inst;
  logic [CYC_W-1:0]  cycle;
  logic              sync, int_rst, int_nmi, int_irq, overrun;
  logic [SRC_W-1:0]  irq_src;

  int total = 0;
  int bad   = 0;

  logic [7:0] m_inst;
  int         m_cyc, m_cause, m_src;
  bit         m_sync, m_ovr, m_pend, m_prev;

  seq_ctrl #(.INST_W(INST_W), .CYC_W(CYC_W), .IRQ_N(IRQ_N), .SRC_W(SRC_W), .INT_OP(INT_OP)) dut (
    .clk(clk), .clr(clr), .dbus(dbus), .icyc(icyc), .rcyc(rcyc), .sinst(sinst),
    .nmi(nmi), .irq(irq), .irq_dis(irq_dis), .inst(inst), .cycle(cycle), .sync(sync),
    .int_rst(int_rst), .int_nmi(int_nmi), .int_irq(int_irq), .irq_src(irq_src),
    .overrun(overrun)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_step();
    bool_t_dummy();
    if (clr) begin
      m_inst = INT_OP; m_cyc = 0; m_sync = 0; m_cause = C_RST; m_src = 0;
      m_ovr = 0; m_pend = 0; m_prev = 0;
    end else begin
      bit fetch_ends, n_pend;
      fetch_ends = m_sync && !rcyc && icyc;
      n_pend = m_pend;
      if (nmi && !m_prev) n_pend = 1;
      else if (sinst && m_cause == C_NMI) n_pend = 0;
      if (fetch_ends) begin
        if (m_pend) begin
          m_inst = INT_OP; m_cause = C_NMI;
        end else if (irq != 0 && !irq_dis) begin
          m_inst = INT_OP; m_cause = C_IRQ;
          for (int i = 0; i < IRQ_N; i++) if (irq[i]) begin m_src = i; break; end
        end else begin
          m_inst = dbus; m_cause = C_NONE;
        end
      end
      if (rcyc) begin
        m_cyc = 0; m_sync = 1;
      end else if (icyc) begin
        if (m_cyc == NCYC - 1) m_ovr = 1;
        m_cyc = (m_cyc + 1) % NCYC; m_sync = 0;
      end
      m_pend = n_pend;
      m_prev = nmi;
    end
  endtask

  task automatic bool_t_dummy();
  endtask

  task automatic check_all();
    chk("inst",    32'(inst),    32'(m_inst));
    chk("cycle",   32'(cycle),   32'(m_cyc));
    chk("sync",    32'(sync),    32'(m_sync));
    chk("int_rst", 32'(int_rst), 32'(m_cause == C_RST));
    chk("int_nmi", 32'(int_nmi), 32'(m_cause == C_NMI));
    chk("int_irq", 32'(int_irq), 32'(m_cause == C_IRQ));
    chk("irq_src", 32'(irq_src), 32'(m_src));
    chk("overrun", 32'(overrun), 32'(m_ovr));
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  initial begin
    clr = 1; icyc = 0; rcyc = 0; sinst = 0; nmi = 0; irq = '0; irq_dis = 0; dbus = 8'h00;
    m_inst = 0; m_cyc = 0; m_cause = 0; m_src = 0; m_sync = 0; m_ovr = 0; m_pend = 0; m_prev = 0;
    tick();
    chk("rst_inst", 32'(inst), 32'h00);
    chk("rst_int_rst", 32'(int_rst), 32'd1);
    chk("rst_sync", 32'(sync), 32'd0);
    clr = 0;

    // Reset sequence counting
    icyc = 1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk("rstseq_cycle", 32'(cycle), 32'(i));
    end
    chk("rstseq_inst", 32'(inst), 32'h00);

    // Plain fetch
    icyc = 0; rcyc = 1; tick();
    chk("fetch_sync", 32'(sync), 32'd1);
    chk("fetch_inst_old", 32'(inst), 32'h00);
    rcyc = 0; icyc = 1; dbus = 8'hA9; tick();
    chk("fetch_inst_new", 32'(inst), 32'hA9);
    chk("fetch_cycle", 32'(cycle), 32'd1);
    chk("fetch_ints", 32'({int_rst, int_nmi, int_irq}), 32'd0);

    // IRQ priority and masking
    icyc = 0; rcyc = 1; tick();
    rcyc = 0; icyc = 1; irq = 4'b1010; dbus = 8'h69; tick();
    chk("irq_inst", 32'(inst), 32'h00);
    chk("irq_flag", 32'(int_irq), 32'd1);
    chk("irq_src1", 32'(irq_src), 32'd1);
    icyc = 0; rcyc = 1; tick();
    rcyc = 0; icyc = 1; irq_dis = 1; tick();
    chk("irqmask_inst", 32'(inst), 32'h69);

    // NMI over IRQ, then acknowledge
    icyc = 0; irq_dis = 0; irq = '0; nmi = 1; tick();
    nmi = 0; rcyc = 1; tick();
    rcyc = 0; icyc = 1; irq = 4'b0001; dbus = 8'hEA; tick();
    chk("nmi_flag", 32'(int_nmi), 32'd1);
    chk("nmi_noirq", 32'(int_irq), 32'd0);
    icyc = 0; sinst = 1; tick();
    sinst = 0; rcyc = 1; tick();
    rcyc = 0; icyc = 1; tick();
    chk("nmiack_irq", 32'(int_irq), 32'd1);
    chk("nmiack_src", 32'(irq_src), 32'd0);

    // Counter wrap without rcyc
    irq = '0; icyc = 0; rcyc = 1; tick();
    chk("wrap_pre_ovr", 32'(overrun), 32'd0);
    rcyc = 0; icyc = 1;
    for (int i = 0; i < 8; i++) tick();
    chk("wrap_cycle", 32'(cycle), 32'd0);
    chk("wrap_ovr", 32'(overrun), 32'd1);
    icyc = 0; tick(); tick();
    chk("wrap_sticky", 32'(overrun), 32'd1);

    // clr at cycle 4 with an NMI pending
    nmi = 1; icyc = 1; tick();
    nmi = 0;
    for (int i = 0; i < 3; i++) tick();
    chk("abort_cycle4", 32'(cycle), 32'd4);
    clr = 1; icyc = 0; tick();
    clr = 0;
    chk("abort_cycle", 32'(cycle), 32'd0);
    chk("abort_inst", 32'(inst), 32'h00);
    chk("abort_rst", 32'(int_rst), 32'd1);
    chk("abort_ovr", 32'(overrun), 32'd0);
    rcyc = 1; tick();
    rcyc = 0; icyc = 1; dbus = 8'hA9; tick();
    chk("abort_nmi_gone", 32'(int_nmi), 32'd0);
    chk("abort_inst2", 32'(inst), 32'hA9);

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      clr     = ($urandom_range(0, 99) == 0);
      rcyc    = ($urandom_range(0, 5) == 0);
      icyc    = ($urandom_range(0, 3) != 0);
      sinst   = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 4) == 0) nmi = ~nmi;
      irq     = ($urandom_range(0, 2) == 0) ? IRQ_N'($urandom) : '0;
      irq_dis = $urandom_range(0, 1) != 0;
      dbus    = INST_W'($urandom);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
